// File: rtl/exec_unit_p.sv
// Multicycle execution unit: one instruction at a time over valid/ready, 16-entry register file,
// ALU/INC/DEC, load/store over a stalling req/ack memory port, branch-on-zero and a sticky error.
module exec_unit_p #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              flag_c,
   output logic              flag_v,
   output logic              flag_z,
   output logic              flag_n,
   output logic              branch_valid,
   output logic [ADDR_W-1:0] branch_target,
   output logic              error,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int MSB = DATA_W - 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MEM  = 2'd2;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_LDR = 4'b1000;
   localparam logic [3:0] OP_STR = 4'b1001;
   localparam logic [3:0] OP_INC = 4'b1010;
   localparam logic [3:0] OP_DEC = 4'b1011;
   localparam logic [3:0] OP_BRZ = 4'b1100;

   logic [1:0]        state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [3:0]        rx_q, rx_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
   logic              branch_valid_q, branch_valid_d;
   logic [ADDR_W-1:0] branch_target_q, branch_target_d;
   logic              error_q, error_d;

   logic [3:0]        in_op, in_rx, in_ry;
   logic              unused_instr_bits;

   assign in_op             = instr[15:12];
   assign in_rx             = instr[11:8];
   assign in_ry             = instr[7:4];
   assign unused_instr_bits = ^instr[3:0];

   logic [DATA_W:0]   alu_sum, alu_diff;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_v, is_add, is_sub;

   // Operands were captured at accept, so rx == ry sees the pre-instruction value twice.
   always_comb begin
      is_add   = (op_q == OP_ADD) || (op_q == OP_INC);
      is_sub   = (op_q == OP_SUB) || (op_q == OP_DEC);
      alu_sum  = {1'b0, a_q} + {1'b0, b_q};
      alu_diff = {1'b0, a_q} - {1'b0, b_q};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      if (is_add) begin
         alu_res = alu_sum[MSB:0];
         alu_c   = alu_sum[DATA_W];
         alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end else if (is_sub) begin
         alu_res = alu_diff[MSB:0];
         alu_c   = alu_diff[DATA_W];
         alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end else begin
         case (op_q[2:0])
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = ~(a_q & b_q);
            3'b100:  alu_res = a_q | b_q;
            3'b101:  alu_res = ~(a_q | b_q);
            3'b110:  alu_res = a_q ^ b_q;
            3'b111:  alu_res = ~(a_q ^ b_q);
            default: alu_res = '0;
         endcase
      end
   end

   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      rx_d            = rx_q;
      a_d             = a_q;
      b_d             = b_q;
      regs_d          = regs_q;
      mem_req_d       = mem_req_q;
      mem_we_d        = mem_we_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      c_d             = c_q;
      v_d             = v_q;
      z_d             = z_q;
      n_d             = n_q;
      branch_valid_d  = 1'b0;
      branch_target_d = branch_target_q;
      error_d         = error_q;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d = in_op;
               rx_d = in_rx;
               a_d  = regs_q[in_rx];
               b_d  = regs_q[in_ry];
               if (!in_op[3]) begin
                  state_d = S_EXEC;
               end else begin
                  case (in_op)
                     OP_INC, OP_DEC: begin
                        state_d = S_EXEC;
                        b_d     = DATA_W'(1);
                     end
                     OP_LDR, OP_STR: begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_op[0];
                        mem_addr_d  = regs_q[in_ry][ADDR_W-1:0];
                        mem_wdata_d = regs_q[in_rx];
                     end
                     OP_BRZ: begin
                        state_d = S_EXEC;
                        if (z_q) begin
                           branch_valid_d  = 1'b1;
                           branch_target_d = regs_q[in_rx][ADDR_W-1:0];
                        end
                     end
                     default: error_d = 1'b1;
                  endcase
               end
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            if (op_q != OP_BRZ) begin
               regs_d[rx_q] = alu_res;
               c_d          = alu_c;
               v_d          = alu_v;
               z_d          = (alu_res == '0);
               n_d          = alu_res[MSB];
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  regs_d[rx_q] = mem_rdata;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         op_q            <= '0;
         rx_q            <= '0;
         a_q             <= '0;
         b_q             <= '0;
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         c_q             <= 1'b0;
         v_q             <= 1'b0;
         z_q             <= 1'b0;
         n_q             <= 1'b0;
         branch_valid_q  <= 1'b0;
         branch_target_q <= '0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         rx_q            <= rx_d;
         a_q             <= a_d;
         b_q             <= b_d;
         mem_req_q       <= mem_req_d;
         mem_we_q        <= mem_we_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         c_q             <= c_d;
         v_q             <= v_d;
         z_q             <= z_d;
         n_q             <= n_d;
         branch_valid_q  <= branch_valid_d;
         branch_target_q <= branch_target_d;
         error_q         <= error_d;
      end
   end

   // Register file is cleared by reset, so it lives in flops rather than a RAM.
   for (genvar gi = 0; gi < 16; gi++) begin : g_regs
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            regs_q[gi] <= '0;
         end else begin
            regs_q[gi] <= regs_d[gi];
         end
      end
   end

   assign instr_ready   = (state_q == S_IDLE);
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign flag_c        = c_q;
   assign flag_v        = v_q;
   assign flag_z        = z_q;
   assign flag_n        = n_q;
   assign branch_valid  = branch_valid_q;
   assign branch_target = branch_target_q;
   assign error         = error_q;
   assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_exec_unit_p.sv
// Bench for exec_unit_p: directed vector table, randomized traffic against a reference model,
// plus reset-during-memory and back-to-back handshake sequences.
module tb_exec_unit_p;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        mem_req, mem_we;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        flag_c, flag_v, flag_z, flag_n;
   logic        branch_valid;
   logic [4:0]  branch_target;
   logic        error;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;

   exec_unit_p #(.DATA_W(16), .ADDR_W(5)) dut (
      .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
      .branch_valid(branch_valid), .branch_target(branch_target), .error(error),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_regs [16];
   bit          m_c, m_v, m_z, m_n, m_err;

   typedef struct {
      logic [3:0]  opc;
      logic [3:0]  rx;
      logic [3:0]  ry;
      int          n_ack;
      logic [15:0] rdata;
      logic [15:0] exp_val;
      logic [3:0]  exp_cvzn;
      logic        exp_err;
   } vec_t;

   vec_t vecs [25];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arithmetic via integer and signed-range reasoning.
   function automatic void model_alu(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] res, output bit c, output bit v);
      int          sa, sb, sr;
      int unsigned ua, ub, full;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      c = 0; v = 0; res = a;
      case (opc)
         4'h0, 4'hA: begin
            full = ua + ub; res = 16'(full % 65536); c = (full >= 65536);
            sr = sa + sb; v = (sr > 32767) || (sr < -32768);
         end
         4'h1, 4'hB: begin
            full = (ua + 65536 - ub) % 65536; res = 16'(full); c = (ua < ub);
            sr = sa - sb; v = (sr > 32767) || (sr < -32768);
         end
         4'h2: res = a & b;
         4'h3: res = ~(a & b);
         4'h4: res = a | b;
         4'h5: res = ~(a | b);
         4'h6: res = a ^ b;
         4'h7: res = ~(a ^ b);
         default: res = a;
      endcase
   endfunction

   // Call just after a falling edge; returns just after a falling edge with the unit idle.
   task automatic issue(input logic [3:0] opc, input logic [3:0] rx, input logic [3:0] ry,
                        input int n_ack, input logic [15:0] rdata);
      logic [15:0] a, b, res;
      bit          c, v;
      a = m_regs[rx];
      b = ((opc == 4'hA) || (opc == 4'hB)) ? 16'd1 : m_regs[ry];
      instr_valid = 1'b1;
      instr = {opc, rx, ry, 4'(($urandom_range(0, 15)))};
      #1 check("ready_at_offer", instr_ready, 1);
      @(posedge clock);
      @(negedge clock);
      instr_valid = 1'b0;
      if (!opc[3] || opc == 4'hA || opc == 4'hB) begin
         check("ready_exec", instr_ready, 0);
         mem_ack = 1'($urandom_range(0, 1));
         model_alu(opc, a, b, res, c, v);
         @(negedge clock);
         mem_ack = 1'b0;
         m_regs[rx] = res;
         m_c = c; m_v = v; m_z = (res == 16'h0); m_n = res[15];
      end else if (opc == 4'h8 || opc == 4'h9) begin
         for (int i = 1; i <= n_ack; i++) begin
            check("mem_req_held", mem_req, 1);
            check("mem_we", mem_we, opc[0]);
            check("mem_addr", mem_addr, m_regs[ry][4:0]);
            check("mem_wdata", mem_wdata, a);
            check("ready_mem", instr_ready, 0);
            mem_ack = (i == n_ack);
            mem_rdata = (i == n_ack) ? rdata : 16'($urandom);
            @(negedge clock);
            mem_ack = 1'b0;
         end
         if (opc == 4'h8) m_regs[rx] = rdata;
      end else if (opc == 4'hC) begin
         check("branch_pulse", branch_valid, m_z);
         if (m_z) check("branch_target", branch_target, a[4:0]);
         check("ready_brz", instr_ready, 0);
         mem_ack = 1'($urandom_range(0, 1));
         @(negedge clock);
         mem_ack = 1'b0;
      end else begin
         m_err = 1;
      end
      dbg_addr = rx;
      #1;
      check("ready_return", instr_ready, 1);
      check("error", error, m_err);
      check("flags_cvzn", {flag_c, flag_v, flag_z, flag_n}, {m_c, m_v, m_z, m_n});
      check("reg_rx", dbg_data, m_regs[rx]);
      check("mem_req_idle", mem_req, 0);
      check("branch_idle", branch_valid, 0);
      $display("txn op=%h rx=%0d ry=%0d -> r%0d=%h cvzn=%b%b%b%b err=%0d",
               opc, rx, ry, rx, m_regs[rx], m_c, m_v, m_z, m_n, m_err);
   endtask

   initial begin
      vecs[0]  = '{4'h8, 4'd1,  4'd0,  1, 16'h7FFF, 16'h7FFF, 4'b0000, 1'b0};
      vecs[1]  = '{4'h0, 4'd1,  4'd1,  1, 16'h0,    16'hFFFE, 4'b0101, 1'b0};
      vecs[2]  = '{4'hB, 4'd2,  4'd0,  1, 16'h0,    16'hFFFF, 4'b1001, 1'b0};
      vecs[3]  = '{4'h1, 4'd2,  4'd2,  1, 16'h0,    16'h0000, 4'b0010, 1'b0};
      vecs[4]  = '{4'h8, 4'd3,  4'd0,  1, 16'h0015, 16'h0015, 4'b0010, 1'b0};
      vecs[5]  = '{4'hC, 4'd3,  4'd0,  1, 16'h0,    16'h0015, 4'b0010, 1'b0};
      vecs[6]  = '{4'h8, 4'd4,  4'd0,  2, 16'h0003, 16'h0003, 4'b0010, 1'b0};
      vecs[7]  = '{4'h9, 4'd1,  4'd4,  4, 16'h0,    16'hFFFE, 4'b0010, 1'b0};
      vecs[8]  = '{4'hE, 4'd1,  4'd2,  1, 16'h0,    16'hFFFE, 4'b0010, 1'b1};
      vecs[9]  = '{4'h4, 4'd5,  4'd1,  1, 16'h0,    16'hFFFE, 4'b0001, 1'b1};
      vecs[10] = '{4'hA, 4'd1,  4'd0,  1, 16'h0,    16'hFFFF, 4'b0001, 1'b1};
      vecs[11] = '{4'hA, 4'd1,  4'd0,  1, 16'h0,    16'h0000, 4'b1010, 1'b1};
      vecs[12] = '{4'hC, 4'd5,  4'd0,  1, 16'h0,    16'hFFFE, 4'b1010, 1'b1};
      vecs[13] = '{4'h3, 4'd6,  4'd1,  1, 16'h0,    16'hFFFF, 4'b0001, 1'b1};
      vecs[14] = '{4'h7, 4'd7,  4'd7,  1, 16'h0,    16'hFFFF, 4'b0001, 1'b1};
      vecs[15] = '{4'h6, 4'd7,  4'd6,  1, 16'h0,    16'h0000, 4'b0010, 1'b1};
      vecs[16] = '{4'h5, 4'd8,  4'd8,  1, 16'h0,    16'hFFFF, 4'b0001, 1'b1};
      vecs[17] = '{4'h2, 4'd8,  4'd3,  1, 16'h0,    16'h0015, 4'b0000, 1'b1};
      vecs[18] = '{4'hC, 4'd3,  4'd0,  1, 16'h0,    16'h0015, 4'b0000, 1'b1};
      vecs[19] = '{4'h1, 4'd3,  4'd4,  1, 16'h0,    16'h0012, 4'b0000, 1'b1};
      vecs[20] = '{4'hD, 4'd3,  4'd3,  1, 16'h0,    16'h0012, 4'b0000, 1'b1};
      vecs[21] = '{4'hF, 4'd2,  4'd2,  1, 16'h0,    16'h0000, 4'b0000, 1'b1};
      vecs[22] = '{4'h8, 4'd10, 4'd0,  3, 16'h8000, 16'h8000, 4'b0000, 1'b1};
      vecs[23] = '{4'hB, 4'd10, 4'd0,  1, 16'h0,    16'h7FFF, 4'b0100, 1'b1};
      vecs[24] = '{4'h1, 4'd11, 4'd10, 1, 16'h0,    16'h8001, 4'b1001, 1'b1};

      reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0; dbg_addr = 4'h0;
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      {m_c, m_v, m_z, m_n, m_err} = 5'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_ready", instr_ready, 1);
      check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
      check("rst_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
      check("rst_branch", {branch_valid, branch_target}, 0);
      check("rst_error", error, 0);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #0.5 check("rst_reg", dbg_data, 0);
      end
      @(negedge clock);

      for (int k = 0; k < 25; k++) begin
         issue(vecs[k].opc, vecs[k].rx, vecs[k].ry, vecs[k].n_ack, vecs[k].rdata);
         dbg_addr = vecs[k].rx;
         #1;
         check("tbl_reg", dbg_data, vecs[k].exp_val);
         check("tbl_flags", {flag_c, flag_v, flag_z, flag_n}, vecs[k].exp_cvzn);
         check("tbl_error", error, vecs[k].exp_err);
      end

      for (int k = 0; k < 150; k++) begin
         issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               $urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      end

      // Reset while a store waits for its ack.
      @(negedge clock);
      instr_valid = 1'b1; instr = 16'h9120;
      @(posedge clock);
      @(negedge clock);
      instr_valid = 1'b0;
      check("pre_rst_mem_req", mem_req, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_mem_req", mem_req, 0);
      check("async_rst_ready", instr_ready, 1);
      check("async_rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
      check("async_rst_state", {flag_c, flag_v, flag_z, flag_n, branch_valid, branch_target, error}, 0);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #0.1 check("async_rst_reg", dbg_data, 0);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      {m_c, m_v, m_z, m_n, m_err} = 5'b0;
      mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      @(negedge clock);
      mem_ack = 1'b0;
      dbg_addr = 4'd1;
      #1;
      check("late_ack_req", mem_req, 0);
      check("late_ack_ready", instr_ready, 1);
      check("late_ack_reg", dbg_data, 0);
      $display("txn reset during MEM, late ack ignored");

      // Back-to-back ADD r1,r2 / LDR r3 (N=1) / XOR r4,r3 with valid held high.
      @(negedge clock);
      instr_valid = 1'b1; instr = 16'h0120;
      #1 check("b2b_ready_e0", instr_ready, 1);
      @(negedge clock);
      check("b2b_exec_add", instr_ready, 0);
      instr = 16'h8300;
      @(negedge clock);
      check("b2b_idle_e1", instr_ready, 1);
      check("b2b_no_req_e1", mem_req, 0);
      check("b2b_add_z", flag_z, 1);
      @(negedge clock);
      check("b2b_ldr_req", mem_req, 1);
      check("b2b_ldr_we", mem_we, 0);
      check("b2b_ldr_ready", instr_ready, 0);
      mem_ack = 1'b1; mem_rdata = 16'h1234; instr = 16'h6430;
      @(negedge clock);
      mem_ack = 1'b0;
      dbg_addr = 4'd3;
      #1;
      check("b2b_ldr_done", mem_req, 0);
      check("b2b_ready_e3", instr_ready, 1);
      check("b2b_r3", dbg_data, 16'h1234);
      @(negedge clock);
      check("b2b_exec_xor", instr_ready, 0);
      instr_valid = 1'b0;
      @(negedge clock);
      dbg_addr = 4'd4;
      #1;
      check("b2b_ready_e5", instr_ready, 1);
      check("b2b_r4", dbg_data, 16'h1234);
      check("b2b_flags", {flag_c, flag_v, flag_z, flag_n}, 4'b0000);
      $display("txn back-to-back ADD/LDR/XOR");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
